// File: rtl/sspat_dec.sv
// Seven-segment pattern decoder: debounces a segment bus and recovers the hex digit.
// Optional saturating illegal-commit counter enabled with SSPAT_DEC_ERRCNT_EN.
module sspat_dec #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [6:0] seg_in,
   output logic [3:0] digit,
   output logic       valid,
   output logic       blank,
   output logic       err
`ifdef SSPAT_DEC_ERRCNT_EN
   ,
   output logic [7:0] err_count
`endif
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] TRACK  = 2'd1;
   localparam logic [1:0] LOCKED = 2'd2;
   localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

   logic [1:0] state;
   logic [6:0] s_q;
   logic [7:0] cnt;
   logic       dec_legal;
   logic [3:0] dec_code;
   logic       is_change;
   logic       commit;

   always_comb begin
      dec_legal = 1'b1;
      dec_code  = 4'h0;
      case (s_q)
         7'h3F: dec_code = 4'h0;
         7'h06: dec_code = 4'h1;
         7'h5B: dec_code = 4'h2;
         7'h4F: dec_code = 4'h3;
         7'h66: dec_code = 4'h4;
         7'h6D: dec_code = 4'h5;
         7'h7D: dec_code = 4'h6;
         7'h07: dec_code = 4'h7;
         7'h7F: dec_code = 4'h8;
         7'h67: dec_code = 4'h9;
         7'h77: dec_code = 4'hA;
         7'h7C: dec_code = 4'hB;
         7'h39: dec_code = 4'hC;
         7'h5E: dec_code = 4'hD;
         7'h79: dec_code = 4'hE;
         7'h71: dec_code = 4'hF;
         default: dec_legal = 1'b0;
      endcase
   end

   // The first sample after IDLE is always a change, even if it equals the cleared s_q.
   assign is_change = (state == IDLE) || (seg_in != s_q);
   assign commit    = enable && (state == TRACK) && (seg_in == s_q) &&
                      ((cnt + 8'd1) == STABLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         s_q   <= 7'h00;
         cnt   <= 8'h00;
         digit <= 4'h0;
         valid <= 1'b0;
         blank <= 1'b0;
         err   <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (!enable) begin
            state <= IDLE;
            s_q   <= 7'h00;
            cnt   <= 8'h00;
         end else if (is_change) begin
            state <= TRACK;
            s_q   <= seg_in;
            cnt   <= 8'd1;
         end else if (state == TRACK) begin
            cnt <= cnt + 8'd1;
            if (commit) begin
               state <= LOCKED;
               if (s_q == 7'h00) begin
                  blank <= 1'b1;
                  err   <= 1'b0;
                  valid <= 1'b1;
               end else if (dec_legal) begin
                  digit <= dec_code;
                  blank <= 1'b0;
                  err   <= 1'b0;
                  valid <= 1'b1;
               end else begin
                  blank <= 1'b0;
                  err   <= 1'b1;
               end
            end
         end
      end
   end

`ifdef SSPAT_DEC_ERRCNT_EN
   // Only rst clears this count; dropping enable leaves it intact.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         err_count <= 8'h00;
      else if (commit && (s_q != 7'h00) && !dec_legal && (err_count != 8'hFF))
         err_count <= err_count + 8'd1;
   end
`endif

endmodule

// File: tb/tb_sspat_dec.sv
// Directed bench for sspat_dec with STABLE_CYCLES = 4; err_count checks
// compile in only when SSPAT_DEC_ERRCNT_EN is defined.
module tb_sspat_dec;

   logic       clk;
   logic       rst;
   logic       enable;
   logic [6:0] seg_in;
   logic [3:0] digit;
   logic       valid;
   logic       blank;
   logic       err;
`ifdef SSPAT_DEC_ERRCNT_EN
   logic [7:0] err_count;
`endif

   int checks = 0;
   int errors = 0;

   sspat_dec #(.STABLE_CYCLES(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .seg_in    (seg_in),
      .digit     (digit),
      .valid     (valid),
      .blank     (blank),
      .err       (err)
`ifdef SSPAT_DEC_ERRCNT_EN
      ,
      .err_count (err_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; enable = 1'b0; seg_in = 7'h00;
      #23;
      rst = 1'b0;
      tick();
      checks++;
      if (digit !== 4'h0 || valid !== 1'b0 || blank !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got digit=%h valid=%b blank=%b err=%b, want 0 0 0 0",
                  digit, valid, blank, err);
      end
`ifdef SSPAT_DEC_ERRCNT_EN
      checks++;
      if (err_count !== 8'd0) begin
         errors++;
         $display("FAIL reset_errcnt: got %0d want 0", err_count);
      end
`endif
   endtask

   task automatic test_decode_hold();
      enable = 1'b1; seg_in = 7'h5B;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (valid !== 1'b0) begin
            errors++;
            $display("FAIL decode_early_valid edge %0d: got %b want 0", i + 1, valid);
         end
      end
      tick();
      checks++;
      if (digit !== 4'h2 || valid !== 1'b1 || blank !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL decode_2: got digit=%h valid=%b blank=%b err=%b, want 2 1 0 0",
                  digit, valid, blank, err);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (valid !== 1'b0 || digit !== 4'h2) begin
            errors++;
            $display("FAIL decode_held: got valid=%b digit=%h, want 0 2", valid, digit);
         end
      end
   endtask

   task automatic test_short_then_long();
      seg_in = 7'h66;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (valid !== 1'b0 || digit !== 4'h2) begin
            errors++;
            $display("FAIL short_66: got valid=%b digit=%h, want 0 2", valid, digit);
         end
      end
      seg_in = 7'h67;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (valid !== 1'b0) begin
            errors++;
            $display("FAIL long_67_early: got valid=%b want 0", valid);
         end
      end
      tick();
      checks++;
      if (digit !== 4'h9 || valid !== 1'b1) begin
         errors++;
         $display("FAIL long_67: got digit=%h valid=%b, want 9 1", digit, valid);
      end
      tick();
      checks++;
      if (valid !== 1'b0) begin
         errors++;
         $display("FAIL long_67_single: got valid=%b want 0", valid);
      end
   endtask

   task automatic test_blank();
      seg_in = 7'h6D;
      repeat (4) tick();
      checks++;
      if (digit !== 4'h5 || valid !== 1'b1) begin
         errors++;
         $display("FAIL digit_5: got digit=%h valid=%b, want 5 1", digit, valid);
      end
      seg_in = 7'h00;
      repeat (3) tick();
      checks++;
      if (valid !== 1'b0 || blank !== 1'b0) begin
         errors++;
         $display("FAIL blank_early: got valid=%b blank=%b, want 0 0", valid, blank);
      end
      tick();
      checks++;
      if (blank !== 1'b1 || valid !== 1'b1 || digit !== 4'h5 || err !== 1'b0) begin
         errors++;
         $display("FAIL blank_commit: got blank=%b valid=%b digit=%h err=%b, want 1 1 5 0",
                  blank, valid, digit, err);
      end
   endtask

   task automatic test_illegal();
      seg_in = 7'h2A;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (valid !== 1'b0) begin
            errors++;
            $display("FAIL illegal_valid edge %0d: got %b want 0", i + 1, valid);
         end
      end
      checks++;
      if (err !== 1'b1 || blank !== 1'b0 || digit !== 4'h5) begin
         errors++;
         $display("FAIL illegal_commit: got err=%b blank=%b digit=%h, want 1 0 5",
                  err, blank, digit);
      end
`ifdef SSPAT_DEC_ERRCNT_EN
      checks++;
      if (err_count !== 8'd1) begin
         errors++;
         $display("FAIL illegal_errcnt: got %0d want 1", err_count);
      end
`endif
   endtask

   task automatic test_enable_drop();
      seg_in = 7'h7F;
      repeat (2) tick();
      enable = 1'b0;
      tick();
      checks++;
      if (valid !== 1'b0 || digit !== 4'h5 || err !== 1'b1) begin
         errors++;
         $display("FAIL drop_hold: got valid=%b digit=%h err=%b, want 0 5 1", valid, digit, err);
      end
      tick();
      enable = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (valid !== 1'b0) begin
            errors++;
            $display("FAIL reenable_early edge %0d: got valid=%b want 0", i + 1, valid);
         end
      end
      tick();
      checks++;
      if (digit !== 4'h8 || valid !== 1'b1 || err !== 1'b0) begin
         errors++;
         $display("FAIL reenable_8: got digit=%h valid=%b err=%b, want 8 1 0", digit, valid, err);
      end
   endtask

   task automatic test_recommit();
      seg_in = 7'h06;
      repeat (2) tick();
      seg_in = 7'h7F;
      repeat (3) tick();
      checks++;
      if (valid !== 1'b0 || digit !== 4'h8) begin
         errors++;
         $display("FAIL recommit_early: got valid=%b digit=%h, want 0 8", valid, digit);
      end
      tick();
      checks++;
      if (valid !== 1'b1 || digit !== 4'h8) begin
         errors++;
         $display("FAIL recommit: got valid=%b digit=%h, want 1 8", valid, digit);
      end
   endtask

   task automatic test_first_zero();
      enable = 1'b0;
      tick();
      enable = 1'b1; seg_in = 7'h00;
      repeat (3) tick();
      checks++;
      if (valid !== 1'b0 || blank !== 1'b0) begin
         errors++;
         $display("FAIL first_zero_early: got valid=%b blank=%b, want 0 0", valid, blank);
      end
      tick();
      checks++;
      if (valid !== 1'b1 || blank !== 1'b1 || digit !== 4'h8) begin
         errors++;
         $display("FAIL first_zero_commit: got valid=%b blank=%b digit=%h, want 1 1 8",
                  valid, blank, digit);
      end
   endtask

`ifdef SSPAT_DEC_ERRCNT_EN
   task automatic test_errcnt_saturate();
      for (int n = 0; n < 300; n++) begin
         seg_in = n[0] ? 7'h2A : 7'h2B;
         repeat (4) tick();
      end
      checks++;
      if (err_count !== 8'd255 || err !== 1'b1) begin
         errors++;
         $display("FAIL errcnt_saturate: got count=%0d err=%b, want 255 1", err_count, err);
      end
      enable = 1'b0;
      tick();
      checks++;
      if (err_count !== 8'd255) begin
         errors++;
         $display("FAIL errcnt_enable_keep: got %0d want 255", err_count);
      end
      enable = 1'b1;
   endtask
`endif

   task automatic test_reset_mid();
      seg_in = 7'h5B;
      repeat (4) tick();
      seg_in = 7'h4F;
      repeat (2) tick();
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (digit !== 4'h0 || valid !== 1'b0 || blank !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: got digit=%h valid=%b blank=%b err=%b, want 0 0 0 0",
                  digit, valid, blank, err);
      end
      #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_early: got valid=%b want 0", valid);
         end
      end
      tick();
      checks++;
      if (digit !== 4'h3 || valid !== 1'b1) begin
         errors++;
         $display("FAIL post_reset_3: got digit=%h valid=%b, want 3 1", digit, valid);
      end
   endtask

   initial begin
      test_reset();
      test_decode_hold();
      test_short_then_long();
      test_blank();
      test_illegal();
      test_enable_drop();
      test_recommit();
      test_first_zero();
`ifdef SSPAT_DEC_ERRCNT_EN
      test_errcnt_saturate();
`endif
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
